// File: rtl/mvm_ctrl.sv
// Matrix-vector multiply sequencer: issues vector/matrix read addresses one word
// per cycle and delays valid/first/last framing to line up with memory read data.
module mvm_ctrl #(
    parameter int unsigned VEC_ADDRW = 8,
    parameter int unsigned MAT_ADDRW = 9,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [VEC_ADDRW-1:0] vec_start_addr,
    input  logic [VEC_ADDRW:0]   vec_num_words,
    input  logic [MAT_ADDRW-1:0] mat_start_addr,
    input  logic [MAT_ADDRW:0]   mat_num_rows,
    output logic [VEC_ADDRW-1:0] vec_raddr,
    output logic [MAT_ADDRW-1:0] mat_raddr,
    output logic                 valid,
    output logic                 first,
    output logic                 last,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [VEC_ADDRW-1:0] VADDR_ONE  = 1;
    localparam logic [MAT_ADDRW-1:0] MADDR_ONE  = 1;
    localparam logic [VEC_ADDRW:0]   WCNT_ONE   = 1;
    localparam logic [MAT_ADDRW:0]   RCNT_ONE   = 1;
    localparam logic [3:0]           DRAIN_LAST = 4'(MEM_LAT - 1);
    localparam logic [3:0]           DRAIN_ONE  = 1;

    state_t state, state_nxt;

    logic [VEC_ADDRW:0]   cfg_words;
    logic [MAT_ADDRW:0]   cfg_rows;
    logic [VEC_ADDRW-1:0] cfg_vec_base;
    logic [VEC_ADDRW:0]   w_cnt;
    logic [MAT_ADDRW:0]   r_cnt;
    logic [3:0]           drain_cnt;

    logic [MEM_LAT-1:0]   pipe_v;
    logic [MEM_LAT-1:0]   pipe_f;
    logic [MEM_LAT-1:0]   pipe_l;

    logic start_ok;
    logic w_last;
    logic r_last;
    logic issue;
    logic issue_first;
    logic issue_last;
    logic done;

    assign start_ok = start && (vec_num_words != '0) && (mat_num_rows != '0);
    assign w_last   = (w_cnt == cfg_words - WCNT_ONE);
    assign r_last   = (r_cnt == cfg_rows - RCNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        issue_first = 1'b0;
        issue_last  = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue       = 1'b1;
                issue_first = (w_cnt == '0);
                issue_last  = w_last;
                done        = w_last && r_last;
                if (done) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address registers double as the issue pointers; they hold after the final issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_words    <= '0;
            cfg_rows     <= '0;
            cfg_vec_base <= '0;
            w_cnt        <= '0;
            r_cnt        <= '0;
            drain_cnt    <= '0;
            vec_raddr    <= '0;
            mat_raddr    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        cfg_words    <= vec_num_words;
                        cfg_rows     <= mat_num_rows;
                        cfg_vec_base <= vec_start_addr;
                        w_cnt        <= '0;
                        r_cnt        <= '0;
                        vec_raddr    <= vec_start_addr;
                        mat_raddr    <= mat_start_addr;
                    end
                end
                RUN: begin
                    if (done) begin
                        drain_cnt <= '0;
                    end else begin
                        mat_raddr <= mat_raddr + MADDR_ONE;
                        if (w_last) begin
                            vec_raddr <= cfg_vec_base;
                            w_cnt     <= '0;
                            r_cnt     <= r_cnt + RCNT_ONE;
                        end else begin
                            vec_raddr <= vec_raddr + VADDR_ONE;
                            w_cnt     <= w_cnt + WCNT_ONE;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DRAIN_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            pipe_f <= '0;
            pipe_l <= '0;
        end else begin
            pipe_v[0] <= issue;
            pipe_f[0] <= issue_first;
            pipe_l[0] <= issue_last;
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_f[i] <= pipe_f[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
        end
    end

    assign valid = pipe_v[MEM_LAT-1];
    assign first = valid & pipe_f[MEM_LAT-1];
    assign last  = valid & pipe_l[MEM_LAT-1];
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mvm_ctrl.sv
// Directed bench for mvm_ctrl: address sequences, framing, busy window,
// ignored starts, address wrap and reset behaviour.
module tb_mvm_ctrl;

    localparam int unsigned VW  = 8;
    localparam int unsigned MW  = 9;
    localparam int unsigned LAT = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [VW-1:0] vec_start_addr;
    logic [VW:0]   vec_num_words;
    logic [MW-1:0] mat_start_addr;
    logic [MW:0]   mat_num_rows;
    logic [VW-1:0] vec_raddr;
    logic [MW-1:0] mat_raddr;
    logic          valid;
    logic          first;
    logic          last;
    logic          busy;

    int checks;
    int errors;

    mvm_ctrl #(
        .VEC_ADDRW(VW),
        .MAT_ADDRW(MW),
        .MEM_LAT  (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .vec_start_addr(vec_start_addr),
        .vec_num_words (vec_num_words),
        .mat_start_addr(mat_start_addr),
        .mat_num_rows  (mat_num_rows),
        .vec_raddr     (vec_raddr),
        .mat_raddr     (mat_raddr),
        .valid         (valid),
        .first         (first),
        .last          (last),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int unsigned ev, input int unsigned em);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".valid"}, 32'(valid), 0);
        chk({tag, ".first"}, 32'(first), 0);
        chk({tag, ".last"}, 32'(last), 0);
        chk({tag, ".vec"}, 32'(vec_raddr), ev);
        chk({tag, ".mat"}, 32'(mat_raddr), em);
    endtask

    // Called at the start of cycle 0; returns in the first cycle busy is expected low.
    task automatic run(input string tag, input int unsigned w, input int unsigned r,
                       input int unsigned vb, input int unsigned mb, input int unsigned pulse_at);
        int unsigned n;
        int unsigned ev, em;
        int          j;
        logic        ex_v, ex_f, ex_l;
        n = w * r;
        start          = 1'b1;
        vec_start_addr = VW'(vb);
        vec_num_words  = (VW+1)'(w);
        mat_start_addr = MW'(mb);
        mat_num_rows   = (MW+1)'(r);
        @(negedge clk);
        start          = 1'b0;
        vec_start_addr = 8'hAA;
        vec_num_words  = 9'd2;
        mat_start_addr = 9'h155;
        mat_num_rows   = 10'd1;
        for (int unsigned c = 1; c <= n + LAT + 1; c++) begin
            if (c - 1 < n) begin
                ev = (vb + (c - 1) % w) % 256;
                em = (mb + c - 1) % 512;
            end else begin
                ev = (vb + w - 1) % 256;
                em = (mb + n - 1) % 512;
            end
            j    = int'(c) - 1 - int'(LAT);
            ex_v = (j >= 0) && (j < int'(n));
            ex_f = ex_v && (int'(j) % int'(w) == 0);
            ex_l = ex_v && (int'(j) % int'(w) == int'(w) - 1);
            chk($sformatf("%s.c%0d.vec", tag, c), 32'(vec_raddr), ev);
            chk($sformatf("%s.c%0d.mat", tag, c), 32'(mat_raddr), em);
            chk($sformatf("%s.c%0d.valid", tag, c), 32'(valid), 32'(ex_v));
            chk($sformatf("%s.c%0d.first", tag, c), 32'(first), 32'(ex_f));
            chk($sformatf("%s.c%0d.last", tag, c), 32'(last), 32'(ex_l));
            chk($sformatf("%s.c%0d.busy", tag, c), 32'(busy), 32'(c <= n + LAT));
            if (c < n + LAT + 1) begin
                start = (c == pulse_at);
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        start          = 1'b1;
        vec_start_addr = 8'd9;
        vec_num_words  = 9'd4;
        mat_start_addr = 9'd9;
        mat_num_rows   = 10'd1;
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset_with_start", 0, 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk_idle("after_reset", 0, 0);

        run("single_row", 4, 1, 0, 0, 0);
        run("two_rows", 3, 2, 5, 10, 0);
        run("w1_rows", 1, 3, 20, 30, 0);
        run("start_ignored", 4, 1, 40, 50, 2);
        run("wrap", 4, 1, 254, 510, 0);

        // Zero-length configurations must leave the block idle.
        start          = 1'b1;
        vec_start_addr = 8'd3;
        vec_num_words  = 9'd0;
        mat_start_addr = 9'd3;
        mat_num_rows   = 10'd5;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned c = 1; c <= 4; c++) begin
            chk_idle($sformatf("w0.c%0d", c), 1, 1);
            @(negedge clk);
        end
        start         = 1'b1;
        vec_num_words = 9'd3;
        mat_num_rows  = 10'd0;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned c = 1; c <= 4; c++) begin
            chk_idle($sformatf("r0.c%0d", c), 1, 1);
            @(negedge clk);
        end

        // Reset in cycle 3 of a W=4, R=2 run, restart in cycle 5.
        start          = 1'b1;
        vec_start_addr = 8'd0;
        vec_num_words  = 9'd4;
        mat_start_addr = 9'd0;
        mat_num_rows   = 10'd2;
        @(negedge clk);
        start = 1'b0;
        chk("midrst.c1.vec", 32'(vec_raddr), 0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst.c3.vec", 32'(vec_raddr), 2);
        chk("midrst.c3.mat", 32'(mat_raddr), 2);
        chk("midrst.c3.valid", 32'(valid), 1);
        chk("midrst.c3.busy", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("midrst.c4", 0, 0);
        @(negedge clk);
        run("after_midrst", 4, 2, 3, 7, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
